// File: rtl/strait_selftest_sequencer.sv
// -----------------------------------------------------------------------------
// strait_selftest_sequencer
//
// Purpose:
//   Self-test controller placed directly upstream of the STRAIT top. A single
//   host request runs memory BIST, then logic BIST (stuck-at then transition-
//   delay), then waits for BISR weight-allocation recovery. It then reports
//   one consolidated pass/fail result with a sticky status vector.
//
// Ports:
//   clk               single clock, shared with STRAIT
//   rst_n             asynchronous active-low reset
//   run               host request level, sampled in IDLE/DONE/ERROR only
//   test_done         STRAIT 1-cycle completion pulse (MBIST, SA, TD)
//   MBIST_FAIL        memory-BIST fail, valid with the MBIST test_done
//   TD_error_flag     transition-delay error flag, taken with the TD test_done
//   recovery_done     BISR allocation finished (pulse or level)
//   recovery_success  BISR result, valid while recovery_done=1
//   START             1-cycle start pulse to STRAIT, one per BIST phase
//   test_mode         STRAIT held in test mode
//   BIST_mode         0 = MBIST, 1 = LBIST
//   busy              sequence in progress
//   done              1-cycle pulse when a sequence ends (pass, fail or abort)
//   pass              sticky final result
//   status            sticky {timeout, td_err, mbist_fail, repair_fail}
//   phase             current FSM state encoding (debug)
// -----------------------------------------------------------------------------
module strait_selftest_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       test_done,
  input  logic       MBIST_FAIL,
  input  logic       TD_error_flag,
  input  logic       recovery_done,
  input  logic       recovery_success,
  output logic       START,
  output logic       test_mode,
  output logic       BIST_mode,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] status,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MB_GO   = 3'd1,
    S_MB_WAIT = 3'd2,
    S_LB_GO   = 3'd3,
    S_LB_WAIT = 3'd4,
    S_REPAIR  = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] wd_q, wd_d;
  logic                 sa_seen_q, sa_seen_d;  // first LBIST completion (SA) seen
  logic                 bist_q, bist_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [3:0]           status_q, status_d;
  logic                 timeout;

  // ">=" rather than "==": when an SA pulse lands on the last allowed cycle the
  // state is kept and the counter steps past the limit, so it must still trip.
  assign timeout = (wd_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    wd_d      = '0;            // cleared on every state entry and outside waits
    sa_seen_d = sa_seen_q;
    bist_d    = bist_q;
    pass_d    = pass_q;
    status_d  = status_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (run) begin
          state_d  = S_MB_GO;
          status_d = 4'b0000;
          pass_d   = 1'b0;
          bist_d   = 1'b0;     // MBIST selected while in MB_GO
        end
      end

      S_MB_GO: state_d = S_MB_WAIT;

      S_MB_WAIT: begin
        if (test_done) begin
          status_d[1] = MBIST_FAIL;
          if (MBIST_FAIL) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_LB_GO;
            bist_d  = 1'b1;    // LBIST selected while in LB_GO
          end
        end else if (timeout) begin
          status_d[3] = 1'b1;
          pass_d      = 1'b0;
          state_d     = S_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_LB_GO: begin
        sa_seen_d = 1'b0;
        state_d   = S_LB_WAIT;
      end

      S_LB_WAIT: begin
        if (test_done) begin
          if (sa_seen_q) begin
            status_d[2] = status_q[2] | TD_error_flag;
            state_d     = S_REPAIR;
          end else begin
            sa_seen_d = 1'b1;
            wd_d      = wd_q + 1'b1;  // same state: watchdog keeps running
          end
        end else if (timeout) begin
          status_d[3] = 1'b1;
          pass_d      = 1'b0;
          state_d     = S_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      S_REPAIR: begin
        // A TD error alone does not fail the result; repair covers it.
        if (recovery_done) begin
          status_d[0] = ~recovery_success;
          pass_d      = ~status_q[1] & recovery_success;
          state_d     = S_DONE;
        end else if (timeout) begin
          status_d[3] = 1'b1;
          pass_d      = 1'b0;
          state_d     = S_ERROR;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    done_d = ((state_d == S_DONE) || (state_d == S_ERROR)) && (state_d != state_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wd_q      <= '0;
      sa_seen_q <= 1'b0;
      bist_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      status_q  <= 4'b0000;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      sa_seen_q <= sa_seen_d;
      bist_q    <= bist_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      status_q  <= status_d;
    end
  end

  assign START     = (state_q == S_MB_GO) || (state_q == S_LB_GO);
  assign test_mode = (state_q == S_MB_GO) || (state_q == S_MB_WAIT) ||
                     (state_q == S_LB_GO) || (state_q == S_LB_WAIT);
  assign busy      = test_mode || (state_q == S_REPAIR);
  assign BIST_mode = bist_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign status    = status_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_strait_selftest_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for strait_selftest_sequencer. A default instance runs a table of full
// sequences; a second instance with a 16-cycle watchdog covers the abort path.
// Expected START pulses and done results are queued when stimulus is driven and
// consumed when the DUT produces them.
// -----------------------------------------------------------------------------
module tb_strait_selftest_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run, test_done, MBIST_FAIL, TD_error_flag, recovery_done, recovery_success;
  logic       START, test_mode, BIST_mode, busy, done, pass;
  logic [3:0] status;
  logic [2:0] phase;

  logic       run_t, test_done_t, MBIST_FAIL_t;
  logic       START_t, test_mode_t, BIST_mode_t, busy_t, done_t, pass_t;
  logic [3:0] status_t;
  logic [2:0] phase_t;

  strait_selftest_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .test_done(test_done),
    .MBIST_FAIL(MBIST_FAIL), .TD_error_flag(TD_error_flag),
    .recovery_done(recovery_done), .recovery_success(recovery_success),
    .START(START), .test_mode(test_mode), .BIST_mode(BIST_mode), .busy(busy),
    .done(done), .pass(pass), .status(status), .phase(phase)
  );

  strait_selftest_sequencer #(.TIMEOUT_CYCLES(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .run(run_t), .test_done(test_done_t),
    .MBIST_FAIL(MBIST_FAIL_t), .TD_error_flag(1'b0),
    .recovery_done(1'b0), .recovery_success(1'b0),
    .START(START_t), .test_mode(test_mode_t), .BIST_mode(BIST_mode_t), .busy(busy_t),
    .done(done_t), .pass(pass_t), .status(status_t), .phase(phase_t)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int done_seen    = 0;

  typedef struct packed {
    logic       p;
    logic [3:0] st;
    int         c;
  } exp_done_t;

  typedef struct packed {
    int   c;
    logic bm;
  } exp_start_t;

  // One sequence: inputs and expected result.
  typedef struct packed {
    logic       mb;     // MBIST_FAIL with the first test_done
    logic       td;     // TD_error_flag with the TD test_done
    logic       rs;     // recovery_success
    logic       stray;  // extra test_done in MB_GO and LB_GO (must be ignored)
    logic       lvl;    // recovery_done raised as a level with the TD test_done
    logic       exp_p;
    logic [3:0] exp_st;
  } vec_t;

  exp_done_t  done_sb[$];
  exp_start_t start_sb[$];
  vec_t       vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, then observe the main DUT just after the edge.
  task automatic step();
    exp_start_t es;
    exp_done_t  ed;
    @(posedge clk);
    #1;
    cyc++;
    if (START) begin
      chk("start_expected", start_sb.size() > 0, 1);
      if (start_sb.size() > 0) begin
        es = start_sb.pop_front();
        chk("start_cycle", cyc, es.c);
        chk("start_bist_mode", BIST_mode, es.bm);
        chk("start_test_mode", test_mode, 1);
      end
    end
    if (done) begin
      done_seen++;
      $display("[TB] done at cycle %0d pass=%0b status=%b", cyc, pass, status);
      chk("done_expected", done_sb.size() > 0, 1);
      if (done_sb.size() > 0) begin
        ed = done_sb.pop_front();
        chk("done_cycle", cyc, ed.c);
        chk("done_pass", pass, ed.p);
        chk("done_status", status, ed.st);
        chk("done_busy", busy, 0);
        chk("done_test_mode", test_mode, 0);
      end
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic run_seq(input vec_t v);
    int t0, n0;
    t0 = cyc;
    n0 = done_seen;
    run = 1'b1;
    start_sb.push_back('{c: t0 + 1, bm: 1'b0});
    step();                                   // t0+1: MB_GO
    run = 1'b0;
    chk("status_cleared", {pass, status}, 5'd0);
    chk("busy_after_run", busy, 1);
    if (v.stray) begin
      test_done  = 1'b1;
      MBIST_FAIL = 1'b1;
    end
    step();
    test_done  = 1'b0;
    MBIST_FAIL = 1'b0;
    wait_until(t0 + 51);
    test_done  = 1'b1;
    MBIST_FAIL = v.mb;
    if (v.mb) done_sb.push_back('{p: v.exp_p, st: v.exp_st, c: t0 + 52});
    else      start_sb.push_back('{c: t0 + 52, bm: 1'b1});
    step();                                   // t0+52: LB_GO or ERROR
    test_done  = 1'b0;
    MBIST_FAIL = 1'b0;
    if (!v.mb) begin
      if (v.stray) test_done = 1'b1;
      step();
      test_done = 1'b0;
      wait_until(t0 + 201);
      test_done = 1'b1;                       // SA completion
      step();
      test_done = 1'b0;
      wait_until(t0 + 300);
      chk("lb_wait_phase", phase, 4);
      chk("lb_wait_test_mode", test_mode, 1);
      chk("lb_wait_bist_mode", BIST_mode, 1);
      wait_until(t0 + 401);
      test_done     = 1'b1;                   // TD completion
      TD_error_flag = v.td;
      if (v.lvl) begin
        recovery_done    = 1'b1;
        recovery_success = v.rs;
        done_sb.push_back('{p: v.exp_p, st: v.exp_st, c: t0 + 403});
      end
      step();                                 // t0+402: REPAIR
      test_done     = 1'b0;
      TD_error_flag = 1'b0;
      chk("repair_phase", phase, 5);
      chk("repair_test_mode", test_mode, 0);
      if (!v.lvl) begin
        wait_until(t0 + 420);
        recovery_done    = 1'b1;
        recovery_success = v.rs;
        done_sb.push_back('{p: v.exp_p, st: v.exp_st, c: t0 + 421});
        step();
        recovery_done    = 1'b0;
        recovery_success = 1'b0;
      end
    end
    while (done_seen == n0 && cyc < t0 + 500) step();
    recovery_done    = 1'b0;
    recovery_success = 1'b0;
    step();
    step();
    chk("done_once", done_seen - n0, 1);
    chk("pass_sticky", pass, v.exp_p);
    chk("status_sticky", status, v.exp_st);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int t0;
    vecs[0] = '{mb: 1'b0, td: 1'b0, rs: 1'b1, stray: 1'b0, lvl: 1'b0, exp_p: 1'b1, exp_st: 4'b0000};
    vecs[1] = '{mb: 1'b1, td: 1'b0, rs: 1'b1, stray: 1'b0, lvl: 1'b0, exp_p: 1'b0, exp_st: 4'b0010};
    vecs[2] = '{mb: 1'b0, td: 1'b1, rs: 1'b1, stray: 1'b0, lvl: 1'b0, exp_p: 1'b1, exp_st: 4'b0100};
    vecs[3] = '{mb: 1'b0, td: 1'b0, rs: 1'b0, stray: 1'b0, lvl: 1'b0, exp_p: 1'b0, exp_st: 4'b0001};
    vecs[4] = '{mb: 1'b0, td: 1'b1, rs: 1'b0, stray: 1'b1, lvl: 1'b1, exp_p: 1'b0, exp_st: 4'b0101};
    vecs[5] = '{mb: 1'b0, td: 1'b0, rs: 1'b1, stray: 1'b1, lvl: 1'b0, exp_p: 1'b1, exp_st: 4'b0000};

    rst_n = 1'b0;
    run = 1'b0; test_done = 1'b0; MBIST_FAIL = 1'b0; TD_error_flag = 1'b0;
    recovery_done = 1'b0; recovery_success = 1'b0;
    run_t = 1'b0; test_done_t = 1'b0; MBIST_FAIL_t = 1'b0;
    step();
    step();
    chk("reset_outputs", {START, test_mode, BIST_mode, busy, done, pass, status, phase}, 0);
    chk("reset_outputs_t", {START_t, test_mode_t, BIST_mode_t, busy_t, done_t, pass_t, status_t, phase_t}, 0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      $display("[TB] sequence %0d: mb=%0b td=%0b rs=%0b stray=%0b lvl=%0b", i,
               vecs[i].mb, vecs[i].td, vecs[i].rs, vecs[i].stray, vecs[i].lvl);
      run_seq(vecs[i]);
    end

    // Reset in the middle of LB_WAIT, then a full sequence again.
    $display("[TB] sequence: reset during LB_WAIT");
    t0 = cyc;
    run = 1'b1;
    start_sb.push_back('{c: t0 + 1, bm: 1'b0});
    step();
    run = 1'b0;
    wait_until(t0 + 51);
    test_done = 1'b1;
    start_sb.push_back('{c: t0 + 52, bm: 1'b1});
    step();
    test_done = 1'b0;
    wait_until(t0 + 100);
    chk("pre_reset_phase", phase, 4);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {START, test_mode, BIST_mode, busy, done, pass, status, phase}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    run_seq(vecs[0]);

    // Watchdog abort in MB_WAIT after 16 wait cycles.
    $display("[TB] sequence: watchdog in MB_WAIT");
    t0 = cyc;
    run_t = 1'b1;
    step();
    run_t = 1'b0;
    chk("to_start", START_t, 1);
    while (!done_t && cyc < t0 + 60) step();
    chk("to_done_cycle", cyc, t0 + 18);
    chk("to_status", status_t, 4'b1000);
    chk("to_pass", pass_t, 0);
    chk("to_test_mode", test_mode_t, 0);
    chk("to_phase", phase_t, 7);

    // test_done on the last allowed cycle wins; LB_WAIT then times out.
    $display("[TB] sequence: test_done beats watchdog");
    t0 = cyc;
    run_t = 1'b1;
    step();
    run_t = 1'b0;
    wait_until(t0 + 17);
    test_done_t = 1'b1;
    step();
    test_done_t = 1'b0;
    chk("race_phase", phase_t, 3);
    chk("race_start", START_t, 1);
    chk("race_bist_mode", BIST_mode_t, 1);
    while (!done_t && cyc < t0 + 80) step();
    chk("race_done_cycle", cyc, t0 + 35);
    chk("race_status", status_t, 4'b1000);
    chk("race_pass", pass_t, 0);

    chk("scoreboard_empty", done_sb.size() + start_sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

endmodule
